// File: rtl/dsram_like_responder_if.sv
// Data SRAM-like bus between the CPU (EX issues, MEM consumes rdata) and the
// data memory responder.
interface dsram_like_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/dsram_like_responder.sv
// Data-memory responder for the SRAM-like bus. Accepts one request per cycle
// into a small in-order queue and answers each one exactly LATENCY cycles
// after acceptance. Reads snapshot the memory word at accept time, so later
// writes never disturb an already-accepted read.
module dsram_like_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input logic clk,
    input logic reset,
    dsram_like_responder_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0]       CNT_INIT = 4'(LATENCY - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0] mem [2**ADDR_W];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_wr;
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_cnt  [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              push;
    logic              pop;

    // size and the byte offset carry no meaning here; upper address bits alias
    logic unused_bits;
    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[1:0],
                           bus.data_sram_addr[31:ADDR_W+2]};

    assign word_idx = bus.data_sram_addr[ADDR_W+1:2];

    // Handshake and response are all combinational from queue state
    always_comb begin
        bus.data_sram_addr_ok = (count != FULL_CNT);
        bus.data_sram_data_ok = ent_valid[rd_ptr] && (ent_cnt[rd_ptr] == 4'd0);
        bus.data_sram_rdata   = 32'd0;
        if (bus.data_sram_data_ok && !ent_wr[rd_ptr]) begin
            bus.data_sram_rdata = ent_data[rd_ptr];
        end
        push = bus.data_sram_req && bus.data_sram_addr_ok;
        pop  = bus.data_sram_data_ok;
    end

    // Byte-lane memory writes; contents survive reset
    always_ff @(posedge clk) begin
        if (push && bus.data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Entry payload: read data is captured before this edge's write lands
    always_ff @(posedge clk) begin
        if (push) begin
            ent_wr[wr_ptr]   <= bus.data_sram_wr;
            ent_data[wr_ptr] <= bus.data_sram_wr ? 32'd0 : mem[word_idx];
        end
    end

    // Queue control: pointers, occupancy, valid bits and latency counters
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i] && ent_cnt[i] != 4'd0) begin
                    ent_cnt[i] <= ent_cnt[i] - 4'd1;
                end
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end
            // the pushed slot is never valid, so it cannot clash with the decrement above
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_cnt[wr_ptr]   <= CNT_INIT;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
